vga_timing_gen: RTL
===================

# vga_timing_gen

Generates 640x480@60 Hz VGA timing from the 100 MHz system clock. It produces a pixel-rate enable, the `h_cnt`/`v_cnt` raster counters consumed by the downstream address generator, and active-low sync strobes. It also provides copies of sync and video-valid delayed by a fixed number of pixel ticks, so they stay aligned with pixel data returning from the address-gen plus frame-BRAM path. It sits directly upstream of the address generator and drives the VGA connector pins.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; 100 MHz / 4 = 25 MHz pixel rate; legal 1..16.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_VISIBLE`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `SYNC_DELAY`, 2: pixel ticks of delay on `*_d` outputs; legal 0..4; 0 = passthrough.
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `pix_en` out 1: one-`clk` pulse per pixel tick.
- `h_cnt` out 10: horizontal position, 0..H_TOTAL-1.
- `v_cnt` out 10: vertical position, 0..V_TOTAL-1.
- `valid` out 1: high when `h_cnt < H_VISIBLE` and `v_cnt < V_VISIBLE`.
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `frame_end` out 1: one-`clk` pulse when the counters wrap from the last pixel of the frame.
- `valid_d` out 1: `valid` delayed by SYNC_DELAY pixel ticks.
- `hsync_d` out 1: `hsync` delayed by SYNC_DELAY pixel ticks.
- `vsync_d` out 1: `vsync` delayed by SYNC_DELAY pixel ticks.

## Operation
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525.
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_en` = (`div_cnt` == CLK_DIV-1), registered. With CLK_DIV=1, `pix_en` is constantly 1 after reset.
- Counters (registered) advance only on `pix_en`:
  - `h_cnt` increments and wraps H_TOTAL-1 -> 0.
  - `v_cnt` increments only on an `h_cnt` wrap, and wraps V_TOTAL-1 -> 0.
- Sync decodes are pure combinational functions of the registered counters:
  - `hsync` = 0 iff H_VISIBLE+H_FP <= `h_cnt` < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - `vsync` = 0 iff 490 <= `v_cnt` <= 491.
- `frame_end` = `pix_en` AND `h_cnt`==H_TOTAL-1 AND `v_cnt`==V_TOTAL-1.
- Delay line: SYNC_DELAY-stage shift register of {`valid`, `hsync`, `vsync`}, shifting only on `pix_en`. It holds its value between ticks.
- All counter comparisons are unsigned, 10-bit. Counters never exceed TOTAL-1.

## Timing
- Reset values, while `rst` is high and in the first cycle after release:
  - `div_cnt`=0, `pix_en`=0, `h_cnt`=0, `v_cnt`=0, `frame_end`=0.
  - `valid`=1 and `hsync`=`vsync`=1, by decode of (0,0).
  - `valid_d`=0 and `hsync_d`=`vsync_d`=1, the delay-stage reset value.
- First `pix_en` occurs CLK_DIV `clk` cycles after `rst` falls. `h_cnt` reads 1 in the cycle after that pulse.
- Each `h_cnt` value is held exactly CLK_DIV `clk` cycles.
- A line is 800 pixel ticks (3200 `clk`); a frame is 420000 pixel ticks.
- `*_d` outputs equal the undelayed signals as they were SYNC_DELAY pixel ticks earlier.
- `rst` asserted mid-frame returns every register to its reset value on the next edge. There is no partial-line completion.
- Simultaneous `h_cnt` wrap and `v_cnt` wrap occur in the same edge, and `frame_end` pulses in that cycle.

## Structure
- Shared package `vga_pkg`: default timing constants (640/16/96/48, 480/10/2/33), derived H_TOTAL/V_TOTAL, and the counter width of 10.
- Sub-module `sync_delay_line`:
  - Parameters: WIDTH, DEPTH.
  - Ports: `clk`, `rst`, `en`, `d`, `q`.
  - Reset value per bit is a parameter, because sync bits reset to 1.
  - DEPTH=0 is a wire passthrough.

## Test plan
- Reset release: hold `rst` 5 cycles then release -> `pix_en` first high at cycle 3 after release, `h_cnt` 0 -> 1 at cycle 4. Also check all reset values.
- Line timing: run 1 line -> `hsync` low for exactly 96 ticks starting at `h_cnt`=656. `valid` high for `h_cnt` 0..639 only. `v_cnt` increments when `h_cnt` goes 799 -> 0.
- Frame wrap: run 1 full frame -> `vsync` low for `v_cnt` 490..491 only. Exactly one `frame_end` pulse, at (799,524), and counters read (0,0) next tick.
- Delay alignment with SYNC_DELAY=2 -> `valid_d` rises 2 pixel ticks (8 `clk`) after `valid`. `hsync_d` falls at `h_cnt`=658.
- Mid-frame reset: assert `rst` at (300,200) for 1 cycle -> next cycle counters (0,0), `pix_en`=0, `valid_d`=0, and normal restart per scenario 1.
- CLK_DIV=1 instance -> `pix_en` constantly 1 after the first cycle, and a line spans 800 `clk`.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared 640x480@60 Hz timing defaults, the derived line/frame totals, the
// raster counter width, the layout of the sync/valid control bundle and a
// small half-open range helper used by the sync decoders.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Control bits that travel together through the alignment delay line.
  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
  } vga_ctrl_t;

  // Idle state of the delay line: video invalid, both syncs deasserted (high).
  localparam vga_ctrl_t CTRL_RST = '{valid: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // True when lo <= x < hi (unsigned).
  function automatic logic in_range(input logic [CNT_W-1:0] x,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// -----------------------------------------------------------------------------
// sync_delay_line
// DEPTH-stage shift register that advances only when en is high and holds
// otherwise. Each stage resets to RST_VAL so active-low sync bits come out of
// reset deasserted. DEPTH = 0 degenerates to a plain wire.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   en   - shift enable (one pulse per pixel tick)
//   d    - input word
//   q    - word as it was DEPTH enabled shifts earlier
// -----------------------------------------------------------------------------
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift chain: stage 0 captures d, later stages take their predecessor.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) begin
            r_stage[k] <= RST_VAL;
          end
        end else if (en) begin
          r_stage[0] <= d;
          for (int k = 1; k < DEPTH; k++) begin
            r_stage[k] <= r_stage[k-1];
          end
        end
      end

      assign q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing from the system clock: a pixel-rate enable, horizontal and
// vertical raster counters, active-low syncs decoded from the counters, a
// frame-end pulse, and copies of valid/hsync/vsync delayed by SYNC_DELAY pixel
// ticks to line up with pixel data coming back from the frame-buffer path.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   pix_en    - one-clk pulse per pixel tick
//   h_cnt     - horizontal position 0..H_TOTAL-1
//   v_cnt     - vertical position 0..V_TOTAL-1
//   valid     - inside the visible area
//   hsync     - active-low horizontal sync
//   vsync     - active-low vertical sync
//   frame_end - pulse on the tick that wraps the last pixel of the frame
//   valid_d   - valid delayed by SYNC_DELAY pixel ticks
//   hsync_d   - hsync delayed by SYNC_DELAY pixel ticks
//   vsync_d   - vsync delayed by SYNC_DELAY pixel ticks
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int SYNC_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             valid,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_end,
  output logic             valid_d,
  output logic             hsync_d,
  output logic             vsync_d
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_next;
  logic             r_pix_en;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  vga_ctrl_t        w_ctrl;
  vga_ctrl_t        w_ctrl_d;
  logic             w_frame_end;

  // Next divider value; wraps at CLK_DIV-1 (stays 0 when CLK_DIV is 1).
  always_comb begin
    w_div_next = {DIV_W{1'b0}};
    if (r_div_cnt == DIV_LAST) begin
      w_div_next = {DIV_W{1'b0}};
    end else begin
      w_div_next = r_div_cnt + DIV_W'(1);
    end
  end

  // Divider and pixel enable. pix_en is registered from the next divider value
  // so it is high during the cycle in which div_cnt reads CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_pix_en  <= 1'b0;
    end else begin
      r_div_cnt <= w_div_next;
      r_pix_en  <= (w_div_next == DIV_LAST);
    end
  end

  // Raster counters: h advances every pixel tick, v advances on each h wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= {CNT_W{1'b0}};
      r_v_cnt <= {CNT_W{1'b0}};
    end else if (r_pix_en) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= {CNT_W{1'b0}};
        if (r_v_cnt == V_LAST) begin
          r_v_cnt <= {CNT_W{1'b0}};
        end else begin
          r_v_cnt <= r_v_cnt + CNT_W'(1);
        end
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end
  end

  // Visible-area and sync decode straight from the registered counters.
  always_comb begin
    w_ctrl       = CTRL_RST;
    w_ctrl.valid = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
    w_ctrl.hsync = ~in_range(r_h_cnt, HS_START, HS_END);
    w_ctrl.vsync = ~in_range(r_v_cnt, VS_START, VS_END);
  end

  assign w_frame_end = r_pix_en && (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

  sync_delay_line #(
    .WIDTH   ($bits(vga_ctrl_t)),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (CTRL_RST)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (r_pix_en),
    .d   (w_ctrl),
    .q   (w_ctrl_d)
  );

  assign pix_en    = r_pix_en;
  assign h_cnt     = r_h_cnt;
  assign v_cnt     = r_v_cnt;
  assign valid     = w_ctrl.valid;
  assign hsync     = w_ctrl.hsync;
  assign vsync     = w_ctrl.vsync;
  assign frame_end = w_frame_end;
  assign valid_d   = w_ctrl_d.valid;
  assign hsync_d   = w_ctrl_d.hsync;
  assign vsync_d   = w_ctrl_d.vsync;

endmodule
